// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared instruction/opcode/error types and the default program for instr_fetch_unit
// INSTR_DEFAULT_PROGRAM backs the ROM used when INSTR_MEM_LOAD_EN is undefined.
package instr_fetch_unit_pkg;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } st_instructionData;

    typedef enum logic [7:0] {
        OP_NOP    = 8'h00,
        OP_I2C_RD = 8'h01,
        OP_I2C_WR = 8'h02,
        OP_END    = 8'hFF
    } opcode_e;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_ADDR       = 4'd1,
        ERR_OVERRUN    = 4'd2,
        ERR_WR_BUSY    = 4'd3,
        ERR_START_BUSY = 4'd4,
        ERR_ABORT      = 4'd5
    } error_e;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, PRESENT, DONE} fsm_state_e;

    localparam logic [31:0] INSTR_DEFAULT_PROGRAM [16] = '{
        32'h0100F000, 32'h021DAB32, 32'hFF000000, 32'h00000000,
        32'h01481122, 32'h02483344, 32'h00000000, 32'hFF000000,
        32'h02500155, 32'h01500100, 32'hFF000000, 32'h00000000,
        32'h00000000, 32'h02771234, 32'h01770000, 32'hFF000000
    };

    // Beyond the table: END every 16 words, and the last four words never END so a late start overruns.
    function automatic logic [31:0] default_word(input int a, input int depth);
        logic [7:0] lo;
        lo = 8'(a);
        if (a < 16) return INSTR_DEFAULT_PROGRAM[a[3:0]];
        if (a >= depth - 4) return {OP_I2C_RD, 8'h50, lo, 8'hA5};
        return (a % 16 == 15) ? {OP_END, 24'h0} : {OP_I2C_WR, 8'h20, lo, ~lo};
    endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// instr_mem_ram: instruction store with one write port and a registered read port
// INSTR_MEM_LOAD_EN builds a zero-initialised RAM; otherwise a ROM of the package default program.
module instr_mem_ram
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DATA_W = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

`ifdef INSTR_MEM_LOAD_EN
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
`else
    logic unused_wr;
    assign unused_wr = ^{we, waddr, wdata};

    always_ff @(posedge clk) rdata <= DATA_W'(default_word(int'(raddr), DEPTH));
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: walks the instruction store from start_addr, presenting each word over valid/ready until END
// INSTR_MEM_LOAD_EN enables runtime program loading through wr_*; otherwise the store is the default ROM.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DATA_W = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    output st_instructionData instr_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [3:0]        error_code
);

    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    st_instructionData data_d, word;
    logic              valid_d, idle, start_ok, wr_ok, last;
    error_e            err_q, err_d;
    logic [DATA_W-1:0] rd_data;

    assign idle       = state_q == IDLE;
    assign start_ok   = int'(start_addr) < DEPTH;
    assign wr_ok      = int'(wr_addr) < DEPTH;
    assign last       = int'(pc_q) == DEPTH - 1;
    assign word       = rd_data;
    assign busy       = !idle;
    assign done       = state_q == DONE && !abort;
    assign error_code = err_q;

    // Writes only land while idle, so the read port never races a write during a program.
    instr_mem_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .we    (wr_en && idle && wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        data_d  = instr_data;
        valid_d = instr_valid;
        err_d   = err_q;
        if (!idle && start) err_d = ERR_START_BUSY;
`ifdef INSTR_MEM_LOAD_EN
        if (!idle && wr_en) err_d = ERR_WR_BUSY;
`endif
        case (state_q)
            IDLE: begin
                if (start && start_ok) begin
                    pc_d    = start_addr;
                    err_d   = ERR_NONE;
                    state_d = FETCH;
                end else if (start) err_d = ERR_ADDR;
`ifdef INSTR_MEM_LOAD_EN
                if (wr_en && !wr_ok) err_d = ERR_ADDR;
`endif
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                state_d = word.op == OP_END ? DONE : PRESENT;
                data_d  = word.op == OP_END ? instr_data : word;
                valid_d = word.op != OP_END;
            end
            PRESENT: if (instr_valid && instr_ready) begin
                valid_d = 1'b0;
                state_d = last ? IDLE : FETCH;
                pc_d    = last ? pc_q : pc_q + 1'b1;
                err_d   = last ? ERR_OVERRUN : err_d;
            end
            default: state_d = IDLE;
        endcase
        // Abort outranks everything, including a handshake in the same cycle.
        if (!idle && abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            err_d   = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_data  <= '0;
            instr_valid <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_data  <= data_d;
            instr_valid <= valid_d;
            err_q       <= err_d;
        end
    end

endmodule
